// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
// clamp_val works on 32-bit values, so counters wider than 32 bits are not supported.
package counter_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    function automatic logic [31:0] clamp_val(input logic [31:0] value,
                                              input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-state for the modulo counter.
// Applies sclr > load > en priority and flags a limit crossing.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2**WIDTH-1,
    parameter int          SATURATE = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic             en,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_evt
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = WIDTH'(clamp_val(32'(load_val), MAX_VAL));

    always_comb begin
        next_count = count;
        wrap_evt   = 1'b0;
        if (sclr) begin
            next_count = '0;
        end else if (load) begin
            next_count = load_clamped;
        end else if (en) begin
            if (up_dn == CNT_UP) begin
                if (count == MAX_C) begin
                    // at the limit: saturating mode holds, otherwise roll to 0
                    next_count = (SATURATE != 0) ? count : '0;
                    wrap_evt   = (SATURATE == 0);
                end else begin
                    next_count = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    next_count = (SATURATE != 0) ? count : MAX_C;
                    wrap_evt   = (SATURATE == 0);
                end else begin
                    next_count = count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Modulo up/down counter: count and wrap registers plus the terminal-count decode.
// All next-state arithmetic lives in counter_next_val.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2**WIDTH-1,
    parameter int          SATURATE = 0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    counter_next_val #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count_q),
        .up_dn      (up_dn),
        .en         (en),
        .sclr       (sclr),
        .load       (load),
        .load_val   (load_val),
        .next_count (count_d),
        .wrap_evt   (wrap_d)
    );

    // rst is active-low despite its name
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_C;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign tc = en & ~sclr & ~load &
                (((up_dn == CNT_UP) && (count_q == MAX_C)) ||
                 ((up_dn == CNT_DOWN) && (count_q == '0)));

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed and randomized checks of counter_updown_mod across five parameter sets
// sharing one stimulus: [0] defaults, [1] mod 10 wrap, [2] mod 10 saturate, [3] mod 100, [4] mod 2.
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, sclr, load;
    logic [7:0] load_val;

    logic [7:0] cnt [5];
    logic       tcv [5];
    logic       wrp [5];

    int unsigned mx  [5] = '{255, 9, 9, 99, 1};
    bit          sat [5] = '{0, 0, 1, 0, 0};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_updown_mod u_a (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sclr(sclr),
        .load(load), .load_val(load_val), .count(cnt[0]), .tc(tcv[0]), .wrap(wrp[0]));
    counter_updown_mod #(.WIDTH(8), .MAX_VAL(9)) u_b (.clk(clk), .rst(rst), .en(en),
        .up_dn(up_dn), .sclr(sclr), .load(load), .load_val(load_val), .count(cnt[1]),
        .tc(tcv[1]), .wrap(wrp[1]));
    counter_updown_mod #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1)) u_c (.clk(clk), .rst(rst),
        .en(en), .up_dn(up_dn), .sclr(sclr), .load(load), .load_val(load_val),
        .count(cnt[2]), .tc(tcv[2]), .wrap(wrp[2]));
    counter_updown_mod #(.WIDTH(8), .MAX_VAL(99)) u_d (.clk(clk), .rst(rst), .en(en),
        .up_dn(up_dn), .sclr(sclr), .load(load), .load_val(load_val), .count(cnt[3]),
        .tc(tcv[3]), .wrap(wrp[3]));
    counter_updown_mod #(.WIDTH(8), .MAX_VAL(1)) u_e (.clk(clk), .rst(rst), .en(en),
        .up_dn(up_dn), .sclr(sclr), .load(load), .load_val(load_val), .count(cnt[4]),
        .tc(tcv[4]), .wrap(wrp[4]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // leaves us 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; sclr = 1'b0; load = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    function automatic void mdl_step(input int unsigned c, input int unsigned m, input bit s,
                                     output int unsigned nc, output bit w);
        nc = c;
        w  = 1'b0;
        if (sclr) nc = 0;
        else if (load) nc = (load_val > m) ? m : load_val;
        else if (en && up_dn) begin
            if (c == m) begin nc = s ? c : 0; w = !s; end
            else nc = c + 1;
        end else if (en) begin
            if (c == 0) begin nc = s ? c : m; w = !s; end
            else nc = c - 1;
        end
    endfunction

    int unsigned mc [5];
    bit          mw [5];

    initial begin
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; sclr = 1'b0; load = 1'b0; load_val = '0;
        #2;
        chk("reset_count", cnt[0], 0);
        chk("reset_wrap", wrp[0], 0);
        chk("reset_tc_en0", tcv[0], 0);

        // 1: async reset mid-count, then count up
        load = 1'b1; load_val = 8'd37;
        #10 rst = 1'b1;
        tick();
        chk("load37", cnt[0], 37);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_count", cnt[0], 0);
        chk("async_rst_wrap", wrp[0], 0);
        rst = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("up_after_rst", cnt[0], i);
        end

        // 2: modulus 10 up count with wrap
        do_reset();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            chk("mod10_tc", tcv[1], (i == 10));
            tick();
            chk("mod10_count", cnt[1], i % 10);
            chk("mod10_wrap", wrp[1], (i == 10));
            chk("sat_up_count", cnt[2], (i < 9) ? i : 9);
        end
        en = 1'b0;
        tick();
        chk("mod10_wrap_drop", wrp[1], 0);
        chk("mod10_hold", cnt[1], 0);

        // 3: down from 0, wrap vs saturate
        do_reset();
        en = 1'b1; up_dn = 1'b0;
        #1;
        chk("down0_tc_wrap", tcv[1], 1);
        chk("down0_tc_sat", tcv[2], 1);
        tick();
        chk("down0_count_wrap", cnt[1], 9);
        chk("down0_wrap_pulse", wrp[1], 1);
        chk("down0_count_sat", cnt[2], 0);
        chk("down0_wrap_sat", wrp[2], 0);
        chk("down0_tc_sat_hold", tcv[2], 1);
        en = 1'b0;

        // 4: load clamp and sclr priority
        load = 1'b1; load_val = 8'd200;
        tick();
        chk("load_clamp99", cnt[3], 99);
        chk("load_nowrap", wrp[3], 0);
        chk("load200_w8", cnt[0], 200);
        sclr = 1'b1;
        tick();
        chk("sclr_beats_load", cnt[3], 0);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        #1;
        chk("tc_masked_sclr", tcv[3], 0);
        sclr = 1'b0;
        #1;
        chk("tc_down_at0", tcv[3], 1);
        load = 1'b1; load_val = 8'd99;
        #1;
        chk("tc_masked_load", tcv[3], 0);
        tick();
        chk("load99_exact", cnt[3], 99);
        load = 1'b1; load_val = 8'd5; en = 1'b0;
        tick();
        load = 1'b0;

        // 5: disabled counter ignores direction
        for (int i = 0; i < 5; i++) begin
            up_dn = ~up_dn;
            #1;
            chk("en0_tc", tcv[0], 0);
            tick();
            chk("en0_count", cnt[0], 5);
            chk("en0_wrap", wrp[0], 0);
        end

        // modulus 2 with alternating direction wraps on every edge
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dn = i[0];
            tick();
            chk("mod2_count", cnt[4], (i % 2 == 0) ? 1 : 0);
            chk("mod2_wrap_cont", wrp[4], 1);
        end

        // 6: random vs reference model
        do_reset();
        for (int k = 0; k < 5; k++) begin mc[k] = 0; mw[k] = 1'b0; end
        for (int n = 0; n < 10000; n++) begin
            en       = ($urandom_range(3) != 0);
            up_dn    = $urandom_range(1);
            sclr     = ($urandom_range(15) == 0);
            load     = ($urandom_range(7) == 0);
            load_val = 8'($urandom_range(255));
            #1;
            for (int k = 0; k < 5; k++) begin
                chk("rnd_tc", tcv[k], en & ~sclr & ~load &
                    ((up_dn & (mc[k] == mx[k])) | (~up_dn & (mc[k] == 0))));
                mdl_step(mc[k], mx[k], sat[k], mc[k], mw[k]);
            end
            tick();
            for (int k = 0; k < 5; k++) begin
                chk("rnd_count", cnt[k], mc[k]);
                chk("rnd_wrap", wrp[k], mw[k]);
                chk("rnd_in_range", (cnt[k] <= mx[k]), 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
